cic3_row_readout_serializer: RTL and testbench
==============================================

Name: cic3_row_readout_serializer

Overview:
Readout end of the 1x12 CIC3 filter row. Captures all twelve 25-bit decimated filter outputs on a sample strobe into a shadow register. Serializes them MSB-first behind a sync word onto a single-bit stream for off-chip capture. Flags dropped samples (overrun) and counts completed frames.

Parameters:
NUM_FILTERS, 12, number of filter channels in the row
DATA_WIDTH, 25, bits per filter output word
SYNC_WORD, 8'hA5, frame header pattern, sent MSB-first
SYNC_WIDTH, 8, header length in bits

Ports:
clk  input  1  common high-speed filter clock
reset_n  input  1  synchronous reset, active low
filt_data  input  NUM_FILTERS*DATA_WIDTH  concatenated filter outputs; channel k at [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH]
sample_strobe  input  1  one-clk pulse: filt_data holds a new decimated sample set
chan_en  input  NUM_FILTERS  per-channel include mask, sampled at capture
overrun_clr  input  1  clears sticky overrun flag
sdo  output  1  serial data out
sdo_valid  output  1  sdo carries a frame bit this cycle
frame_sync  output  1  high on the first header bit only
busy  output  1  frame in progress
overrun  output  1  sticky: strobe dropped while busy
frame_cnt  output  8  completed-frame counter

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-low on reset_n. All outputs and state are registered.
- Reset values: sdo=0, sdo_valid=0, frame_sync=0, busy=0, overrun=0, frame_cnt=0, FSM in IDLE, shadow register=0.
- FSM states are IDLE, SYNC, DATA and, with the optional feature only, PAR.
- IDLE:
  - On sample_strobe, latch filt_data and chan_en into shadow registers at that edge.
  - Go to SYNC. The first header bit appears on sdo in the next cycle (latency 1 clk from strobe to first sdo_valid).
- SYNC: shift out SYNC_WIDTH bits MSB-first. frame_sync=1 on bit 0 of the header only. Then go to DATA at the lowest-index enabled channel, or end the frame if no channel is enabled.
- DATA:
  - Shift the current channel word MSB-first over DATA_WIDTH cycles, in ascending channel order.
  - Disabled channels are skipped and consume zero cycles.
  - After the last bit, go to the next enabled channel, or end the frame.
- Frame length = SYNC_WIDTH + DATA_WIDTH*(number of enabled channels). A full frame is 8+300=308 cycles.
- sdo_valid=1 and busy=1 for every frame bit cycle; both are 0 otherwise. sdo=0 when sdo_valid=0.
- frame_cnt increments by 1 in the cycle after the last frame bit and wraps 255->0.
- Back-to-back frames: a sample_strobe coincident with the last bit of a frame is accepted. The shadow register is reloaded and SYNC starts the next cycle, so sdo_valid stays continuously high.
- Strobe at any other busy cycle is dropped:
  - overrun is set next cycle.
  - The frame in progress and the shadow data are unaffected.
- overrun_clr clears overrun. If overrun_clr and a drop occur in the same cycle, set wins.
- filt_data and chan_en changes outside the capture edge have no effect on the frame in progress.
- reset_n low mid-frame aborts the frame. Next edge: all outputs at reset values. No partial frame resumes after release.

Optional Feature:
Macro CIC3_READOUT_PARITY_EN.
- Defined: after each channel word, state PAR emits one even-parity bit (XOR of the 25 data bits), with sdo_valid=1. Frame length = SYNC_WIDTH + (DATA_WIDTH+1)*enabled channels; a full frame is 320 cycles.
- Undefined: no PAR state, no parity bits, frame length as in Behaviour.

Test Plan:
1. Reset, chan_en=12'hFFF, channel k word = k+1, one strobe -> next cycle frame_sync=1; sdo = 10100101, then 25'd1 ... 25'd12 MSB-first; sdo_valid high exactly 308 cycles; then frame_cnt=1, busy=0.
2. chan_en=12'h005, channel0=25'h1ABCDEF, channel2=25'h0000001, strobe -> 58-bit frame: header, 25'h1ABCDEF, 25'h0000001; channel 1 absent. chan_en=0 -> 8-bit header-only frame, frame_cnt increments.
3. Strobe at frame bit 100 with changed filt_data -> overrun=1 next cycle, transmitted frame matches originally captured data. Pulse overrun_clr -> overrun=0. overrun_clr coincident with a new drop -> overrun stays 1.
4. Strobe on bit 307 of a full frame -> second frame's header starts next cycle; sdo_valid continuous for 616 cycles; frame_cnt=2. Run 256 frames -> frame_cnt wraps to 0.
5. reset_n low for 1 cycle at frame bit 150 -> next edge sdo_valid=0, busy=0, frame_cnt=0, overrun=0. A later strobe yields a complete, correct 308-bit frame.
6. With CIC3_READOUT_PARITY_EN, chan_en=12'h001, channel0=25'h0000007 -> 34-bit frame, final bit 1. With channel0=25'h0000003 -> final bit 0.

Source files
------------

// File: rtl/cic3_row_readout_serializer.sv
// CIC3 filter row readout: shadow-captures all channel words on a strobe and
// serializes them MSB-first behind a sync header. Optional CIC3_READOUT_PARITY_EN.
module cic3_row_readout_serializer #(
  parameter int unsigned           NUM_FILTERS = 12,
  parameter int unsigned           DATA_WIDTH  = 25,
  parameter int unsigned           SYNC_WIDTH  = 8,
  parameter logic [SYNC_WIDTH-1:0] SYNC_WORD   = 8'hA5
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NUM_FILTERS*DATA_WIDTH-1:0] filt_data,
  input  logic                              sample_strobe,
  input  logic [NUM_FILTERS-1:0]            chan_en,
  input  logic                              overrun_clr,
  output logic                              sdo,
  output logic                              sdo_valid,
  output logic                              frame_sync,
  output logic                              busy,
  output logic                              overrun,
  output logic [7:0]                        frame_cnt
);

  localparam int unsigned CNT_MAX = (DATA_WIDTH > SYNC_WIDTH) ? DATA_WIDTH : SYNC_WIDTH;
  localparam int unsigned BW      = $clog2(CNT_MAX);
  localparam int unsigned CW      = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
  localparam logic [BW-1:0] SYNC_LAST = BW'(SYNC_WIDTH - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_WIDTH - 1);

`ifdef CIC3_READOUT_PARITY_EN
  typedef enum logic [1:0] {IDLE, SYNC, DATA, PAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, SYNC, DATA} state_t;
`endif

  state_t                 state;
  logic [BW-1:0]          bit_cnt;
  logic [DATA_WIDTH-1:0]  shreg;
  logic [DATA_WIDTH-1:0]  shadow_word [NUM_FILTERS];
  logic [NUM_FILTERS-1:0] pend_en;
`ifdef CIC3_READOUT_PARITY_EN
  logic                   par_acc;
`endif

  logic                   found;
  logic [CW-1:0]          nxt_idx;
  logic [DATA_WIDTH-1:0]  nxt_word;
  logic                   last_bit;
  logic                   load_nxt;
  logic                   accept;
  logic                   drop;

  // pend_en holds the captured mask minus channels already started, so the
  // lowest set bit is always the next channel to send.
  always_comb begin
    found   = 1'b0;
    nxt_idx = '0;
    for (int unsigned i = NUM_FILTERS; i > 0; i--) begin
      if (pend_en[i-1]) begin
        found   = 1'b1;
        nxt_idx = CW'(i - 1);
      end
    end
  end

  assign nxt_word = shadow_word[nxt_idx];

  always_comb begin
    last_bit = 1'b0;
    load_nxt = 1'b0;
    case (state)
      SYNC: begin
        last_bit = (bit_cnt == SYNC_LAST) && !found;
        load_nxt = (bit_cnt == SYNC_LAST) && found;
      end
`ifdef CIC3_READOUT_PARITY_EN
      PAR: begin
        last_bit = !found;
        load_nxt = found;
      end
`else
      DATA: begin
        last_bit = (bit_cnt == DATA_LAST) && !found;
        load_nxt = (bit_cnt == DATA_LAST) && found;
      end
`endif
      default: ;
    endcase
  end

  assign accept = sample_strobe && ((state == IDLE) || last_bit);
  assign drop   = sample_strobe && (state != IDLE) && !last_bit;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      pend_en    <= '0;
      sdo        <= 1'b0;
      sdo_valid  <= 1'b0;
      frame_sync <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      frame_cnt  <= '0;
      for (int unsigned k = 0; k < NUM_FILTERS; k++) shadow_word[k] <= '0;
`ifdef CIC3_READOUT_PARITY_EN
      par_acc    <= 1'b0;
`endif
    end else begin
      frame_sync <= 1'b0;
      if (drop)             overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
      if (last_bit) frame_cnt <= frame_cnt + 1'b1;

      if (accept) begin
        for (int unsigned k = 0; k < NUM_FILTERS; k++)
          shadow_word[k] <= filt_data[k*DATA_WIDTH +: DATA_WIDTH];
        pend_en    <= chan_en;
        state      <= SYNC;
        bit_cnt    <= '0;
        sdo        <= SYNC_WORD[SYNC_WIDTH-1];
        shreg      <= {SYNC_WORD[SYNC_WIDTH-2:0], {(DATA_WIDTH-SYNC_WIDTH+1){1'b0}}};
        sdo_valid  <= 1'b1;
        busy       <= 1'b1;
        frame_sync <= 1'b1;
      end else if (last_bit) begin
        state     <= IDLE;
        sdo       <= 1'b0;
        sdo_valid <= 1'b0;
        busy      <= 1'b0;
      end else if (load_nxt) begin
        state            <= DATA;
        pend_en[nxt_idx] <= 1'b0;
        bit_cnt          <= '0;
        sdo              <= nxt_word[DATA_WIDTH-1];
        shreg            <= {nxt_word[DATA_WIDTH-2:0], 1'b0};
`ifdef CIC3_READOUT_PARITY_EN
        par_acc          <= nxt_word[DATA_WIDTH-1];
`endif
      end else if (state != IDLE) begin
`ifdef CIC3_READOUT_PARITY_EN
        if (state == DATA && bit_cnt == DATA_LAST) begin
          state <= PAR;
          sdo   <= par_acc;
        end else
`endif
        begin
          bit_cnt <= bit_cnt + 1'b1;
          sdo     <= shreg[DATA_WIDTH-1];
          shreg   <= {shreg[DATA_WIDTH-2:0], 1'b0};
`ifdef CIC3_READOUT_PARITY_EN
          par_acc <= par_acc ^ shreg[DATA_WIDTH-1];
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_cic3_row_readout_serializer.sv
// Scoreboard bench for cic3_row_readout_serializer: expected frame bits are
// queued at each accepted strobe and popped by a negedge stream monitor.
module tb_cic3_row_readout_serializer;

  localparam int NF = 12;
  localparam int DW = 25;
  localparam int SW = 8;
`ifdef CIC3_READOUT_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FULL = SW + (DW + P) * NF;

  typedef struct packed {logic b; logic s;} exp_t;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [NF*DW-1:0] filt_data = '0;
  logic             sample_strobe = 1'b0;
  logic [NF-1:0]    chan_en = '0;
  logic             overrun_clr = 1'b0;
  logic             sdo, sdo_valid, frame_sync, busy, overrun;
  logic [7:0]       frame_cnt;

  int   tests = 0;
  int   fails = 0;
  int   vcount = 0;
  int   icount = 0;
  exp_t sb[$];
  exp_t mon_e;

  cic3_row_readout_serializer #(
    .NUM_FILTERS(NF), .DATA_WIDTH(DW), .SYNC_WIDTH(SW), .SYNC_WORD(8'hA5)
  ) dut (
    .clk(clk), .reset_n(reset_n), .filt_data(filt_data),
    .sample_strobe(sample_strobe), .chan_en(chan_en), .overrun_clr(overrun_clr),
    .sdo(sdo), .sdo_valid(sdo_valid), .frame_sync(frame_sync), .busy(busy),
    .overrun(overrun), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  function automatic void push_frame(input logic [NF*DW-1:0] d, input logic [NF-1:0] en);
    exp_t          e;
    logic [SW-1:0] sw;
    logic [DW-1:0] w;
    sw = 8'hA5;
    for (int i = SW - 1; i >= 0; i--) begin
      e.b = sw[i]; e.s = (i == SW - 1); sb.push_back(e);
    end
    for (int ch = 0; ch < NF; ch++) begin
      if (en[ch]) begin
        w = d[ch*DW +: DW];
        for (int i = DW - 1; i >= 0; i--) begin
          e.b = w[i]; e.s = 1'b0; sb.push_back(e);
        end
        if (P == 1) begin
          e.b = ^w; e.s = 1'b0; sb.push_back(e);
        end
      end
    end
  endfunction

  function automatic logic [NF*DW-1:0] ramp_data();
    logic [NF*DW-1:0] d;
    for (int k = 0; k < NF; k++) d[k*DW +: DW] = DW'(k + 1);
    return d;
  endfunction

  // Stream monitor: every frame bit against the scoreboard, idle sdo low.
  always @(negedge clk) begin
    if (sdo_valid === 1'b1) begin
      vcount++;
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL stream_extra: sdo_valid=1 with no expected bit at %0t", $time);
      end else begin
        mon_e = sb.pop_front();
        if (sdo !== mon_e.b || frame_sync !== mon_e.s) begin
          fails++;
          $display("FAIL stream_bit: sdo=%b sync=%b, expected sdo=%b sync=%b at %0t",
                   sdo, frame_sync, mon_e.b, mon_e.s, $time);
        end
      end
    end else begin
      icount++;
      tests++;
      if (sdo !== 1'b0 || frame_sync !== 1'b0) begin
        fails++;
        $display("FAIL idle_out: sdo=%b sync=%b, expected 0 0 at %0t", sdo, frame_sync, $time);
      end
    end
    tests++;
    if (busy !== sdo_valid) begin
      fails++;
      $display("FAIL busy_vs_valid: busy=%b sdo_valid=%b at %0t", busy, sdo_valid, $time);
    end
  end

  // Caller may be anywhere; strobe is driven at posedge+1 for one cycle.
  // The scoreboard gets the frame only when the bench's own queue says the
  // DUT is idle (empty) or on its last bit (one entry left).
  task automatic do_strobe(input logic [NF*DW-1:0] d, input logic [NF-1:0] en, input logic clr);
    @(posedge clk); #1;
    filt_data = d; chan_en = en; sample_strobe = 1'b1; overrun_clr = clr;
    if (sb.size() <= 1) push_frame(d, en);
    @(posedge clk); #1;
    sample_strobe = 1'b0; overrun_clr = 1'b0;
    for (int k = 0; k < NF; k++) filt_data[k*DW +: DW] = DW'($urandom());
    chan_en = ~en;
  endtask

  task automatic drain(input int limit, output int n, output int v, output logic lastb);
    n = 0; v = 0; lastb = 1'b0;
    while (sb.size() != 0 && n < limit) begin
      @(negedge clk); #1;
      n++;
      if (sdo_valid) begin v++; lastb = sdo; end
    end
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    sb.delete();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    tests++;
    if ({sdo, sdo_valid, frame_sync, busy, overrun} !== 5'b0) begin
      fails++;
      $display("FAIL reset_flags: got %b, expected 00000", {sdo, sdo_valid, frame_sync, busy, overrun});
    end
    tests++;
    if (frame_cnt !== 8'd0) begin
      fails++; $display("FAIL reset_cnt: frame_cnt=%0d, expected 0", frame_cnt);
    end
  endtask

  task automatic test_full_frame();
    int n, v; logic lb;
    do_strobe(ramp_data(), 12'hFFF, 1'b0);
    tests++;
    if (frame_sync !== 1'b1 || sdo_valid !== 1'b1 || sdo !== 1'b1) begin
      fails++;
      $display("FAIL first_bit: sync=%b valid=%b sdo=%b, expected 1 1 1", frame_sync, sdo_valid, sdo);
    end
    drain(FULL + 20, n, v, lb);
    tests++;
    if (sb.size() != 0 || v != FULL || n != FULL) begin
      fails++;
      $display("FAIL full_len: valid=%0d cycles=%0d left=%0d, expected %0d", v, n, sb.size(), FULL);
    end
    @(negedge clk); #1;
    tests++;
    if (frame_cnt !== 8'd1 || busy !== 1'b0) begin
      fails++; $display("FAIL full_end: frame_cnt=%0d busy=%b, expected 1 0", frame_cnt, busy);
    end
  endtask

  task automatic test_sparse_channels();
    int n, v; logic lb; logic [NF*DW-1:0] d; logic [7:0] c0;
    d = '0;
    d[0*DW +: DW] = 25'h1ABCDEF;
    d[1*DW +: DW] = 25'h0AAAAAA;
    d[2*DW +: DW] = 25'h0000001;
    do_strobe(d, 12'h005, 1'b0);
    drain(200, n, v, lb);
    tests++;
    if (sb.size() != 0 || v != SW + 2 * (DW + P)) begin
      fails++; $display("FAIL sparse_len: valid=%0d, expected %0d", v, SW + 2 * (DW + P));
    end
    @(negedge clk); #1;
    c0 = frame_cnt;
    do_strobe(d, 12'h000, 1'b0);
    drain(50, n, v, lb);
    tests++;
    if (sb.size() != 0 || v != SW) begin
      fails++; $display("FAIL header_only_len: valid=%0d, expected %0d", v, SW);
    end
    @(negedge clk); #1;
    tests++;
    if (frame_cnt !== c0 + 8'd1) begin
      fails++; $display("FAIL header_only_cnt: frame_cnt=%0d, expected %0d", frame_cnt, c0 + 8'd1);
    end
  endtask

  task automatic test_overrun();
    int n, v; logic lb;
    tests++;
    if (overrun !== 1'b0) begin
      fails++; $display("FAIL overrun_pre: overrun=%b, expected 0", overrun);
    end
    do_strobe(ramp_data(), 12'hFFF, 1'b0);
    repeat (99) @(posedge clk);
    #1;
    do_strobe(~ramp_data(), 12'hFFF, 1'b0);
    tests++;
    if (overrun !== 1'b1) begin
      fails++; $display("FAIL overrun_set: overrun=%b, expected 1", overrun);
    end
    @(posedge clk); #1; overrun_clr = 1'b1;
    @(posedge clk); #1; overrun_clr = 1'b0;
    tests++;
    if (overrun !== 1'b0) begin
      fails++; $display("FAIL overrun_clr: overrun=%b, expected 0", overrun);
    end
    do_strobe(~ramp_data(), 12'h0F0, 1'b1);
    tests++;
    if (overrun !== 1'b1) begin
      fails++; $display("FAIL overrun_set_wins: overrun=%b, expected 1", overrun);
    end
    drain(FULL + 20, n, v, lb);
    tests++;
    if (sb.size() != 0) begin
      fails++; $display("FAIL overrun_drain: %0d bits left, expected 0", sb.size());
    end
    @(posedge clk); #1; overrun_clr = 1'b1;
    @(posedge clk); #1; overrun_clr = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n, v, v0, i0, guard; logic lb;
    apply_reset();
    do_strobe(ramp_data(), 12'hFFF, 1'b0);
    v0 = vcount; i0 = icount;
    guard = 0;
    while (sb.size() > 2 && guard < FULL + 20) begin
      @(posedge clk); #1; guard++;
    end
    do_strobe(~ramp_data(), 12'hFFF, 1'b0);
    drain(FULL + 20, n, v, lb);
    tests++;
    if (sb.size() != 0 || vcount - v0 != 2 * FULL || icount != i0) begin
      fails++;
      $display("FAIL b2b_cont: valid=%0d idle=%0d, expected %0d 0", vcount - v0, icount - i0, 2 * FULL);
    end
    @(negedge clk); #1;
    tests++;
    if (frame_cnt !== 8'd2) begin
      fails++; $display("FAIL b2b_cnt: frame_cnt=%0d, expected 2", frame_cnt);
    end
    for (int f = 0; f < 253; f++) begin
      do_strobe('0, 12'h000, 1'b0);
      drain(50, n, v, lb);
    end
    @(negedge clk); #1;
    tests++;
    if (frame_cnt !== 8'd255) begin
      fails++; $display("FAIL cnt_255: frame_cnt=%0d, expected 255", frame_cnt);
    end
    do_strobe('0, 12'h000, 1'b0);
    drain(50, n, v, lb);
    @(negedge clk); #1;
    tests++;
    if (frame_cnt !== 8'd0 || sb.size() != 0) begin
      fails++; $display("FAIL cnt_wrap: frame_cnt=%0d left=%0d, expected 0 0", frame_cnt, sb.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    int n, v; logic lb;
    do_strobe(ramp_data(), 12'hFFF, 1'b0);
    repeat (19) @(posedge clk);
    #1;
    do_strobe(ramp_data(), 12'h001, 1'b0);
    tests++;
    if (overrun !== 1'b1) begin
      fails++; $display("FAIL mid_overrun: overrun=%b, expected 1", overrun);
    end
    repeat (129) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    sb.delete();
    reset_n = 1'b1;
    tests++;
    if ({sdo_valid, busy, overrun} !== 3'b000 || frame_cnt !== 8'd0) begin
      fails++;
      $display("FAIL mid_reset: valid=%b busy=%b overrun=%b cnt=%0d, expected 0 0 0 0",
               sdo_valid, busy, overrun, frame_cnt);
    end
    repeat (5) @(posedge clk);
    tests++;
    if (sdo_valid !== 1'b0) begin
      fails++; $display("FAIL mid_no_resume: sdo_valid=%b, expected 0", sdo_valid);
    end
    do_strobe(ramp_data(), 12'hFFF, 1'b0);
    drain(FULL + 20, n, v, lb);
    tests++;
    if (sb.size() != 0 || v != FULL) begin
      fails++; $display("FAIL mid_refrm: valid=%0d, expected %0d", v, FULL);
    end
  endtask

`ifdef CIC3_READOUT_PARITY_EN
  task automatic test_parity();
    int n, v; logic lb; logic [NF*DW-1:0] d;
    d = '0; d[DW-1:0] = 25'h0000007;
    do_strobe(d, 12'h001, 1'b0);
    drain(100, n, v, lb);
    tests++;
    if (v != 34 || lb !== 1'b1) begin
      fails++; $display("FAIL parity_odd: len=%0d last=%b, expected 34 1", v, lb);
    end
    d[DW-1:0] = 25'h0000003;
    do_strobe(d, 12'h001, 1'b0);
    drain(100, n, v, lb);
    tests++;
    if (v != 34 || lb !== 1'b0) begin
      fails++; $display("FAIL parity_even: len=%0d last=%b, expected 34 0", v, lb);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_full_frame();
    test_sparse_channels();
    test_overrun();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef CIC3_READOUT_PARITY_EN
    test_parity();
`endif
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
